// File: rtl/commit_dests.sv
// Commits a two-destination result bundle to the x86 register file and/or a memory write port.
// Fixed four-state sequence; memory destinations stall in their state until the write handshake.
module commit_dests (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [1:0]  dest0_kind,
   input  logic [1:0]  dest1_kind,
   input  logic [31:0] dest0_sel,
   input  logic [31:0] dest1_sel,
   input  logic [31:0] res0,
   input  logic [31:0] res1,
   input  logic        reg_1byte,
   input  logic        prefix_operand_16bit,
   output logic [31:0] eax,
   output logic [31:0] ecx,
   output logic [31:0] edx,
   output logic [31:0] ebx,
   output logic [31:0] esp,
   output logic [31:0] ebp,
   output logic [31:0] esi,
   output logic [31:0] edi,
   output logic        mem_wr_valid,
   input  logic        mem_wr_ready,
   output logic [31:0] mem_wr_addr,
   output logic [31:0] mem_wr_data,
   output logic [3:0]  mem_wr_be,
   output logic        commit_done,
   output logic        kind_err
);

   typedef enum logic [1:0] {StIdle, StWr0, StWr1, StDone} state_t;

   localparam logic [1:0] KindReg = 2'b01;
   localparam logic [1:0] KindMem = 2'b10;
   localparam logic [1:0] KindBad = 2'b11;

   state_t      state_q;
   logic [1:0]  kind0_q, kind1_q;
   logic [31:0] sel0_q, sel1_q, res0_q, res1_q;
   logic        byte_q, half_q;
   logic [31:0] gpr_q [8];

   logic        in_wr, advance;
   logic [1:0]  cur_kind;
   logic [31:0] cur_sel, cur_res, wr_val;
   logic [2:0]  wr_idx;

   assign in_wr    = (state_q == StWr0) || (state_q == StWr1);
   assign cur_kind = (state_q == StWr1) ? kind1_q : kind0_q;
   assign cur_sel  = (state_q == StWr1) ? sel1_q  : sel0_q;
   assign cur_res  = (state_q == StWr1) ? res1_q  : res0_q;

   // Outputs decode only registered state, so an async reset clears them at once.
   assign in_ready     = (state_q == StIdle);
   assign commit_done  = (state_q == StDone);
   assign mem_wr_valid = in_wr && (cur_kind == KindMem);
   assign mem_wr_addr  = mem_wr_valid ? cur_sel : '0;
   assign mem_wr_data  = mem_wr_valid ? cur_res : '0;
   assign mem_wr_be    = !mem_wr_valid ? 4'b0000 :
                         byte_q        ? 4'b0001 :
                         half_q        ? 4'b0011 : 4'b1111;
   assign advance      = !mem_wr_valid || mem_wr_ready;

   // Byte writes to sel 4-7 land in bits [15:8] of eax..ebx (AH..BH).
   always_comb begin
      wr_idx = cur_sel[2:0];
      if (byte_q) wr_idx = {1'b0, cur_sel[1:0]};
      wr_val = gpr_q[wr_idx];
      if (byte_q) begin
         if (cur_sel[2]) wr_val[15:8] = cur_res[7:0];
         else            wr_val[7:0]  = cur_res[7:0];
      end else if (half_q) begin
         wr_val[15:0] = cur_res[15:0];
      end else begin
         wr_val = cur_res;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         kind0_q  <= '0;
         kind1_q  <= '0;
         sel0_q   <= '0;
         sel1_q   <= '0;
         res0_q   <= '0;
         res1_q   <= '0;
         byte_q   <= 1'b0;
         half_q   <= 1'b0;
         kind_err <= 1'b0;
         for (int i = 0; i < 8; i++) gpr_q[i] <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (in_valid) begin
                  kind0_q <= dest0_kind;
                  kind1_q <= dest1_kind;
                  sel0_q  <= dest0_sel;
                  sel1_q  <= dest1_sel;
                  res0_q  <= res0;
                  res1_q  <= res1;
                  byte_q  <= reg_1byte;
                  half_q  <= prefix_operand_16bit;
                  state_q <= StWr0;
               end
            end
            StWr0:   if (advance) state_q <= StWr1;
            StWr1:   if (advance) state_q <= StDone;
            StDone:  state_q <= StIdle;
            default: state_q <= StIdle;
         endcase
         if (in_wr && (cur_kind == KindReg)) gpr_q[wr_idx] <= wr_val;
         if (in_wr && (cur_kind == KindBad)) kind_err <= 1'b1;
      end
   end

   assign eax = gpr_q[0];
   assign ecx = gpr_q[1];
   assign edx = gpr_q[2];
   assign ebx = gpr_q[3];
   assign esp = gpr_q[4];
   assign ebp = gpr_q[5];
   assign esi = gpr_q[6];
   assign edi = gpr_q[7];

endmodule

// File: tb/tb_commit_dests.sv
// Bench for commit_dests: transaction-level register/memory model checked every cycle,
// directed scenarios with literal expectations, then randomized bundles.
module tb_commit_dests;

   logic        clk, rst, in_valid, in_ready;
   logic [1:0]  dest0_kind, dest1_kind;
   logic [31:0] dest0_sel, dest1_sel, res0, res1;
   logic        reg_1byte, prefix_operand_16bit;
   logic [31:0] eax, ecx, edx, ebx, esp, ebp, esi, edi;
   logic        mem_wr_valid, mem_wr_ready;
   logic [31:0] mem_wr_addr, mem_wr_data;
   logic [3:0]  mem_wr_be;
   logic        commit_done, kind_err;

   commit_dests dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .dest0_kind(dest0_kind), .dest1_kind(dest1_kind),
      .dest0_sel(dest0_sel), .dest1_sel(dest1_sel), .res0(res0), .res1(res1),
      .reg_1byte(reg_1byte), .prefix_operand_16bit(prefix_operand_16bit),
      .eax(eax), .ecx(ecx), .edx(edx), .ebx(ebx), .esp(esp), .ebp(ebp), .esi(esi), .edi(edi),
      .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready), .mem_wr_addr(mem_wr_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_be(mem_wr_be),
      .commit_done(commit_done), .kind_err(kind_err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Reference state: architectural registers plus expected handshake outputs.
   logic [31:0] m_reg [8];
   logic        exp_in_ready, exp_done, exp_mv, exp_kerr;
   logic [31:0] exp_addr, exp_data;
   logic [3:0]  exp_be;
   logic [31:0] dut_reg [8];
   int          n_checks, n_pass, mv_cycles;
   logic        checking;

   assign dut_reg[0] = eax;
   assign dut_reg[1] = ecx;
   assign dut_reg[2] = edx;
   assign dut_reg[3] = ebx;
   assign dut_reg[4] = esp;
   assign dut_reg[5] = ebp;
   assign dut_reg[6] = esi;
   assign dut_reg[7] = edi;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
   endtask

   function automatic void reset_model();
      for (int i = 0; i < 8; i++) m_reg[i] = '0;
      exp_in_ready = 1'b1;
      exp_done     = 1'b0;
      exp_mv       = 1'b0;
      exp_addr     = '0;
      exp_data     = '0;
      exp_be       = '0;
      exp_kerr     = 1'b0;
   endfunction

   // Architectural effect of one register destination.
   function automatic void model_write(input logic [31:0] sel, input logic [31:0] res,
                                       input logic b1, input logic w16);
      int idx;
      if (b1) begin
         idx = int'(sel[1:0]);
         if (sel[2]) m_reg[idx][15:8] = res[7:0];
         else        m_reg[idx][7:0]  = res[7:0];
      end else if (w16) begin
         idx = int'(sel[2:0]);
         m_reg[idx][15:0] = res[15:0];
      end else begin
         idx = int'(sel[2:0]);
         m_reg[idx] = res;
      end
   endfunction

   always @(negedge clk) begin
      if (checking) begin
         if (!rst) check("in_ready", in_ready, exp_in_ready);
         check("commit_done", commit_done, exp_done);
         check("mem_wr_valid", mem_wr_valid, exp_mv);
         if (exp_mv || rst) begin
            check("mem_wr_addr", mem_wr_addr, exp_addr);
            check("mem_wr_data", mem_wr_data, exp_data);
            check("mem_wr_be", mem_wr_be, exp_be);
         end
         check("kind_err", kind_err, exp_kerr);
         for (int i = 0; i < 8; i++) check($sformatf("reg%0d", i), dut_reg[i], m_reg[i]);
         if (mem_wr_valid) mv_cycles++;
      end
   end

   task automatic bundle(input logic [1:0] k0, input logic [31:0] s0, input logic [31:0] r0,
                         input logic [1:0] k1, input logic [31:0] s1, input logic [31:0] r1,
                         input logic b1, input logic w16, input int st0, input int st1,
                         input int idle);
      logic [1:0]  k [2];
      logic [31:0] s [2];
      logic [31:0] r [2];
      int          st [2];
      k[0] = k0; k[1] = k1; s[0] = s0; s[1] = s1; r[0] = r0; r[1] = r1;
      st[0] = st0; st[1] = st1;
      repeat (idle) begin
         @(posedge clk); #1;
      end
      dest0_kind = k0; dest0_sel = s0; res0 = r0;
      dest1_kind = k1; dest1_sel = s1; res1 = r1;
      reg_1byte = b1; prefix_operand_16bit = w16;
      in_valid = 1'b1;
      @(posedge clk); #1;
      // Scramble inputs: the accepted bundle must be latched.
      in_valid = 1'b0;
      dest0_kind = 2'($urandom); dest0_sel = $urandom; res0 = $urandom;
      dest1_kind = 2'($urandom); dest1_sel = $urandom; res1 = $urandom;
      reg_1byte = 1'($urandom); prefix_operand_16bit = 1'($urandom);
      exp_in_ready = 1'b0;
      for (int d = 0; d < 2; d++) begin
         if (k[d] == 2'b10) begin
            for (int c = 0; c <= st[d]; c++) begin
               mem_wr_ready = (c == st[d]);
               exp_mv   = 1'b1;
               exp_addr = s[d];
               exp_data = r[d];
               exp_be   = b1 ? 4'b0001 : (w16 ? 4'b0011 : 4'b1111);
               @(posedge clk); #1;
            end
            exp_mv = 1'b0;
            mem_wr_ready = 1'($urandom);
         end else begin
            mem_wr_ready = 1'($urandom);
            @(posedge clk); #1;
            if (k[d] == 2'b01) model_write(s[d], r[d], b1, w16);
            else if (k[d] == 2'b11) exp_kerr = 1'b1;
         end
      end
      exp_done = 1'b1;
      @(posedge clk); #1;
      exp_done = 1'b0;
      exp_in_ready = 1'b1;
   endtask

   initial begin
      n_checks = 0; n_pass = 0; mv_cycles = 0; checking = 1'b0;
      rst = 1'b1; in_valid = 1'b0; mem_wr_ready = 1'b0;
      dest0_kind = '0; dest1_kind = '0; dest0_sel = '0; dest1_sel = '0;
      res0 = '0; res1 = '0; reg_1byte = 1'b0; prefix_operand_16bit = 1'b0;
      reset_model();
      #7 checking = 1'b1;
      @(posedge clk); #1;
      check("reset eax", eax, 32'h0);
      check("reset mem_wr_be", {28'h0, mem_wr_be}, 32'h0);
      rst = 1'b0;

      // Register commit latency and value.
      bundle(2'b01, 32'd3, 32'hDEADBEEF, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 1);
      check("ebx literal", ebx, 32'hDEADBEEF);

      // Byte-high and 16-bit writes.
      bundle(2'b01, 32'd0, 32'h11223344, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 0);
      bundle(2'b01, 32'd4, 32'h000000AB, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 0, 0, 0);
      check("eax AH literal", eax, 32'h1122AB44);
      bundle(2'b01, 32'd0, 32'h0000CAFE, 2'b00, 32'd0, 32'd0, 1'b0, 1'b1, 0, 0, 0);
      check("eax 16b literal", eax, 32'h1122CAFE);

      // Stalled memory write: three wait cycles.
      mv_cycles = 0;
      bundle(2'b10, 32'h1000, 32'h55, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 3, 0, 0);
      check("mem valid cycles", mv_cycles, 32'd4);

      // Same register twice, then an illegal kind.
      bundle(2'b01, 32'd1, 32'h1, 2'b01, 32'd1, 32'h2, 1'b0, 1'b0, 0, 0, 0);
      check("ecx literal", ecx, 32'h2);
      bundle(2'b11, 32'd2, 32'h77, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 0);
      check("kind_err literal", kind_err, 1'b1);
      check("edx untouched", edx, 32'h0);
      bundle(2'b00, 32'd0, 32'd0, 2'b01, 32'd6, 32'h9, 1'b0, 1'b0, 0, 0, 0);
      check("kind_err sticky", kind_err, 1'b1);

      // Reset during a memory stall in WR0.
      dest0_kind = 2'b10; dest0_sel = 32'h2000; res0 = 32'h1234;
      dest1_kind = 2'b01; dest1_sel = 32'd2; res1 = 32'h99;
      reg_1byte = 1'b0; prefix_operand_16bit = 1'b0;
      mem_wr_ready = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; exp_in_ready = 1'b0;
      exp_mv = 1'b1; exp_addr = 32'h2000; exp_data = 32'h1234; exp_be = 4'b1111;
      @(posedge clk); #1;
      rst = 1'b1;
      reset_model();
      #1;
      check("abort mem_wr_valid", mem_wr_valid, 1'b0);
      check("abort eax", eax, 32'h0);
      check("abort kind_err", kind_err, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(posedge clk); #1;
      end
      bundle(2'b01, 32'd3, 32'hDEADBEEF, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 0, 0, 0);
      check("post-abort ebx", ebx, 32'hDEADBEEF);
      check("post-abort edx", edx, 32'h0);

      // Randomized bundles.
      for (int n = 0; n < 150; n++) begin
         logic [31:0] s0, s1;
         s0 = $urandom; s1 = $urandom;
         if ($urandom_range(0, 1) == 0) s1 = s0;
         bundle(2'($urandom), s0, $urandom, 2'($urandom), s1, $urandom,
                ($urandom_range(0, 2) == 0), 1'($urandom),
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
      end

      checking = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/commit_dests.md
COMMIT_DESTS -- requirements
Module: commit_dests

Interface
REQ-001 SHALL have: clk  in  1  sole clock; all state on rising edge.
REQ-002 SHALL have: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have: in_valid  in  1  decoded destination bundle valid.
REQ-004 SHALL have: in_ready  out  1  block idle, bundle accepted when in_valid && in_ready.
REQ-005 SHALL have: dest0_kind, dest1_kind  in  2 each  one-hot kind: 00 none, bit0 register, bit1 memory, 11 illegal.
REQ-006 SHALL have: dest0_sel, dest1_sel  in  32 each  register selector in [2:0] (upper bits ignored) or memory address.
REQ-007 SHALL have: res0, res1  in  32 each  result values for dest0/dest1.
REQ-008 SHALL have: reg_1byte, prefix_operand_16bit  in  1 each  write width qualifiers.
REQ-009 SHALL have: eax, ecx, edx, ebx, esp, ebp, esi, edi  out  32 each  architectural register file.
REQ-010 SHALL have: mem_wr_valid  out  1; mem_wr_ready  in  1; mem_wr_addr  out  32; mem_wr_data  out  32; mem_wr_be  out  4.
REQ-011 SHALL have: commit_done  out  1  one-cycle pulse per completed bundle; kind_err  out  1  sticky illegal-kind flag.

Function
REQ-012 SHALL implement FSM states IDLE, WR0, WR1, DONE; in_ready = 1 only in IDLE.
REQ-013 SHALL latch all bundle inputs on acceptance; later input changes SHALL have no effect until next acceptance.
REQ-014 SHALL go IDLE -> WR0 on acceptance, WR0 -> WR1, WR1 -> DONE, DONE -> IDLE, each one cycle unless stalled per REQ-018.
REQ-015 SHALL commit dest0 in WR0 and dest1 in WR1; kind none consumes its state cycle with no write (fixed latency).
REQ-016 Register selector mapping SHALL be 0 eax, 1 ecx, 2 edx, 3 ebx, 4 esp, 5 ebp, 6 esi, 7 edi; register write takes effect at end of the WRn cycle.
REQ-017 Register width: reg_1byte -> sel 0-3 write bits [7:0] of eax/ecx/edx/ebx, sel 4-7 write bits [15:8] of eax/ecx/edx/ebx (AH..BH); else prefix_operand_16bit -> bits [15:0]; else all 32; unwritten bits SHALL hold.
REQ-018 Memory kind: in WRn, assert mem_wr_valid with mem_wr_addr = dest_sel, mem_wr_data = res; stay in WRn until mem_wr_ready sampled high, then advance.
REQ-019 mem_wr_addr/data/be SHALL remain stable while mem_wr_valid && !mem_wr_ready; mem_wr_valid SHALL be 0 outside memory-kind WRn.
REQ-020 mem_wr_be SHALL be 0001 if reg_1byte, 0011 if prefix_operand_16bit (and not reg_1byte), else 1111; mem_wr_data SHALL carry res unshifted.
REQ-021 Same register in dest0 and dest1: dest1 value SHALL be final (later write wins per width rule).
REQ-022 Kind 11 SHALL be treated as none and SHALL set kind_err, held until reset.
REQ-023 commit_done SHALL be 1 exactly in DONE; zero-wait latency from acceptance cycle T: done at T+3, in_ready at T+4.
REQ-024 Memory writes at a register sel and register writes at an address SHALL NOT occur: kind alone selects target.

Reset
REQ-025 On rst high, immediately: state IDLE, all eight registers 0, mem_wr_valid 0, mem_wr_addr/data 0, mem_wr_be 0, commit_done 0, kind_err 0, in_ready 1 after release.
REQ-026 rst asserted mid-bundle (incl. during memory stall) SHALL abort the bundle with no further writes and no commit_done.

Verification
REQ-027 Reset, bundle dest0 reg sel 3 res0 0xDEADBEEF, dest1 none -> ebx = 0xDEADBEEF at T+2, commit_done at T+3, in_ready at T+4.
REQ-028 eax = 0x11223344, reg_1byte, dest0 reg sel 4 res0 0xAB -> eax = 0x1122AB44; prefix_operand_16bit sel 0 res0 0xCAFE -> eax = 0x1122CAFE.
REQ-029 dest0 mem addr 0x1000 res0 0x55, reg_1byte, mem_wr_ready low 3 cycles -> mem_wr_valid held 4 cycles, addr/data/be 0x1000/0x55/0001 stable, done one cycle after handshake.
REQ-030 dest0 reg sel 1 res0 0x1, dest1 reg sel 1 res1 0x2 -> ecx = 0x2 at done; dest0_kind 11 -> no write, kind_err 1 persists across later bundles.
REQ-031 rst pulsed while mem stall in WR0 -> mem_wr_valid drops same cycle, registers 0, no commit_done, next bundle behaves per REQ-027.
